// File: rtl/io_out_arbiter.sv
// Two-writer arbiter for the four front-panel output registers (LED + three hex banks).
// Round-robin by default; define IO_ARB_CORE_PRIO_EN to give requester A fixed priority.
module io_out_arbiter #(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQA,
    input  logic [1:0]        ADDRA,
    input  logic [DATA_W-1:0] DATAA,
    output logic              GNTA,
    input  logic              REQB,
    input  logic [1:0]        ADDRB,
    input  logic [DATA_W-1:0] DATAB,
    output logic              GNTB,
    output logic [DATA_W-1:0] OUTD,
    output logic [DATA_W-1:0] OUTE,
    output logic [DATA_W-1:0] OUTF,
    output logic [DATA_W-1:0] OUTG,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state;
    logic              owner;      // 0 = A, 1 = B
    logic [1:0]        lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              pick_b;
    logic              owner_req;

`ifdef IO_ARB_CORE_PRIO_EN
    assign pick_b = REQB && !REQA;
`else
    logic last;                    // previous winner, 1 = B
    assign pick_b = REQB && (!REQA || !last);
`endif

    assign owner_req = owner ? REQB : REQA;

    // NOTE: every register below is updated with non-blocking assignments so all
    // branches see the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            owner    <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            GNTA     <= 1'b0;
            GNTB     <= 1'b0;
            BUSY     <= 1'b0;
            OUTD     <= RESET_VAL;
            OUTE     <= RESET_VAL;
            OUTF     <= RESET_VAL;
            OUTG     <= RESET_VAL;
`ifndef IO_ARB_CORE_PRIO_EN
            last     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (REQA || REQB) begin
                        owner    <= pick_b;
                        lat_addr <= pick_b ? ADDRB : ADDRA;
                        lat_data <= pick_b ? DATAB : DATAA;
                        state    <= WRITE;
                        BUSY     <= 1'b1;
`ifndef IO_ARB_CORE_PRIO_EN
                        last     <= pick_b;
`endif
                    end
                end
                WRITE: begin
                    case (lat_addr)
                        2'd0:    OUTD <= lat_data;
                        2'd1:    OUTE <= lat_data;
                        2'd2:    OUTF <= lat_data;
                        default: OUTG <= lat_data;
                    endcase
                    GNTA  <= !owner;
                    GNTB  <= owner;
                    state <= ACK;
                end
                ACK: begin
                    // Hold the grant until the owner completes its half of the handshake.
                    if (!owner_req) begin
                        GNTA  <= 1'b0;
                        GNTB  <= 1'b0;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
